// File: rtl/vga_monitor.sv
// VGA timing monitor: decodes pixels, checks sync periods and active sizes, counts frames.
// Optional per-frame CRC-16-CCITT output enabled by defining VGA_MONITOR_CRC_EN.
module vga_monitor #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic                     CLK,
  input  logic                     NRST,
  input  logic                     VGA_HS,
  input  logic                     VGA_VS,
  input  logic                     VGA_BLANK,
  input  logic [7:0]               VGA_R,
  input  logic [7:0]               VGA_G,
  input  logic [7:0]               VGA_B,
  input  logic                     err_clr,
  output logic                     pix_valid,
  output logic [$clog2(HDISP)-1:0] pix_x,
  output logic [$clog2(VDISP)-1:0] pix_y,
  output logic [23:0]              pix_rgb,
  output logic                     frame_done,
  output logic [15:0]              frame_cnt,
  output logic                     locked,
  output logic                     hs_err,
  output logic                     vs_err,
  output logic                     size_err
`ifdef VGA_MONITOR_CRC_EN
  ,
  output logic [15:0]              frame_crc
`endif
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int XW     = $clog2(HDISP);
  localparam int YW     = $clog2(VDISP);
  localparam logic [XW-1:0] XLAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] YLAST = YW'(VDISP - 1);

  typedef enum logic [1:0] {WAIT_VS, WAIT_ACT, IN_FRAME} state_t;

  state_t      r_state;
  logic        r_hs_d, r_vs_d, r_blank_d;
  logic        r_hs_seen, r_vs_seen, r_frame_err;
  logic [15:0] r_hs_per, r_vs_per, r_px, r_lines;

  logic        w_hs_fall, w_vs_fall, w_act, w_line_end, w_frame_end;
  logic        w_hs_ev, w_vs_ev, w_size_ev, w_any_ev;
  logic [15:0] w_vs_cnt;

  assign w_hs_fall   = r_hs_d & ~VGA_HS;
  assign w_vs_fall   = r_vs_d & ~VGA_VS;
  // The WAIT_ACT -> IN_FRAME cycle already carries the first pixel of the frame.
  assign w_act       = VGA_BLANK && (r_state != WAIT_VS);
  assign w_line_end  = r_blank_d && !VGA_BLANK && (r_state == IN_FRAME);
  assign w_frame_end = w_vs_fall && (r_state == IN_FRAME);
  // A coincident HS edge closes the vertical period that this VS edge ends.
  assign w_vs_cnt    = r_vs_per + 16'(w_hs_fall);

  assign w_hs_ev   = w_hs_fall && r_hs_seen && (r_hs_per != 16'(HTOTAL));
  assign w_vs_ev   = (w_vs_fall && r_vs_seen && (w_vs_cnt != 16'(VTOTAL)))
                   || (VGA_BLANK && !VGA_VS);
  assign w_size_ev = (w_line_end && (r_px != 16'(HDISP)))
                   || (w_frame_end && (r_lines != 16'(VDISP)));
  assign w_any_ev  = w_hs_ev | w_vs_ev | w_size_ev;

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_state     <= WAIT_VS;
      r_hs_d      <= 1'b1;
      r_vs_d      <= 1'b1;
      r_blank_d   <= 1'b0;
      r_hs_seen   <= 1'b0;
      r_vs_seen   <= 1'b0;
      r_frame_err <= 1'b0;
      r_hs_per    <= '0;
      r_vs_per    <= '0;
      r_px        <= '0;
      r_lines     <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      locked      <= 1'b0;
      hs_err      <= 1'b0;
      vs_err      <= 1'b0;
      size_err    <= 1'b0;
    end else begin
      r_hs_d    <= VGA_HS;
      r_vs_d    <= VGA_VS;
      r_blank_d <= VGA_BLANK;

      if (w_hs_fall) begin
        r_hs_per  <= 16'd1;
        r_hs_seen <= 1'b1;
      end else if (r_hs_per != '1) begin
        r_hs_per <= r_hs_per + 1'b1;
      end

      if (w_vs_fall) begin
        r_vs_per  <= '0;
        r_vs_seen <= 1'b1;
      end else if (w_hs_fall && (r_vs_per != '1)) begin
        r_vs_per <= r_vs_per + 1'b1;
      end

      pix_valid <= w_act;
      if (w_act) begin
        pix_rgb <= {VGA_R, VGA_G, VGA_B};
        if (!r_blank_d) begin
          pix_x   <= '0;
          pix_y   <= (r_lines >= 16'(VDISP - 1)) ? YLAST : r_lines[YW-1:0];
          r_px    <= 16'd1;
          r_lines <= (r_lines == '1) ? r_lines : r_lines + 1'b1;
        end else begin
          pix_x <= (r_px >= 16'(HDISP - 1)) ? XLAST : r_px[XW-1:0];
          r_px  <= (r_px == '1) ? r_px : r_px + 1'b1;
        end
      end

      // VS edge wins over any pixel/line update in the same cycle.
      if (w_vs_fall) begin
        r_px    <= '0;
        r_lines <= '0;
        pix_x   <= '0;
        pix_y   <= '0;
      end

      case (r_state)
        WAIT_VS:  if (w_vs_fall) r_state <= WAIT_ACT;
        WAIT_ACT: if (!w_vs_fall && VGA_BLANK) r_state <= IN_FRAME;
        IN_FRAME: if (w_vs_fall) r_state <= WAIT_ACT;
        default:  r_state <= WAIT_VS;
      endcase

      frame_done <= w_frame_end;
      if (w_frame_end) frame_cnt <= frame_cnt + 1'b1;

      hs_err   <= (hs_err   & ~err_clr) | w_hs_ev;
      vs_err   <= (vs_err   & ~err_clr) | w_vs_ev;
      size_err <= (size_err & ~err_clr) | w_size_ev;

      r_frame_err <= w_vs_fall ? 1'b0 : (r_frame_err | w_any_ev);
      if (w_any_ev)         locked <= 1'b0;
      else if (w_frame_end) locked <= ~r_frame_err;
    end
  end

`ifdef VGA_MONITOR_CRC_EN
  logic [15:0] r_crc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] v;
    logic        fb;
    v = c;
    for (int unsigned i = 0; i < 24; i++) begin
      fb = v[15] ^ d[23 - i];
      v  = {v[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return v;
  endfunction

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_crc     <= 16'hFFFF;
      frame_crc <= 16'hFFFF;
    end else begin
      if (w_vs_fall)  r_crc <= 16'hFFFF;
      else if (w_act) r_crc <= crc_step(r_crc, {VGA_R, VGA_G, VGA_B});
      if (w_frame_end) frame_crc <= r_crc;
    end
  end
`endif

endmodule

// File: doc/vga_monitor.md
VGA_MONITOR -- requirements
Module: vga_monitor

Interface
REQ-001 Parameter HDISP, default 800: active pixels per line.
REQ-002 Parameter VDISP, default 480: active lines per frame.
REQ-003 Parameters HFP/HPULSE/HBP, defaults 40/48/40: horizontal front porch, sync pulse and back porch, in pixel clocks.
REQ-004 Parameters VFP/VPULSE/VBP, defaults 13/3/29: vertical front porch, sync pulse and back porch, in lines.
REQ-005 Derived values: HTOTAL = HDISP+HFP+HPULSE+HBP; VTOTAL = VDISP+VFP+VPULSE+VBP.
REQ-006 CLK  in  1: pixel clock; the only clock in the block.
REQ-007 NRST  in  1: reset, synchronous and active-low.
REQ-008 VGA_HS  in  1: horizontal sync, active-low.
REQ-009 VGA_VS  in  1: vertical sync, active-low.
REQ-010 VGA_BLANK  in  1: high means a displayed pixel, low means blanking.
REQ-011 VGA_R, VGA_G, VGA_B  in  8 each: pixel colour.
REQ-012 err_clr  in  1: clears all sticky error flags.
REQ-013 pix_valid  out  1: pix_x, pix_y and pix_rgb hold a decoded pixel.
REQ-014 pix_x  out  $clog2(HDISP); pix_y  out  $clog2(VDISP); pix_rgb  out  24 {R,G,B}.
REQ-015 frame_done  out  1: one-cycle pulse at the end of each frame.
REQ-016 frame_cnt  out  16: number of completed frames.
REQ-017 locked  out  1: a full frame with no errors has been received.
REQ-018 hs_err, vs_err, size_err  out  1 each: sticky error flags.

Function
REQ-019 The block SHALL register HS and VS into history flops and detect falling edges (1 -> 0) only.
REQ-020 The FSM SHALL have three states: WAIT_VS, WAIT_ACT and IN_FRAME.
- WAIT_VS -> WAIT_ACT on a VS falling edge.
- WAIT_ACT -> IN_FRAME on the first cycle with BLANK=1.
- IN_FRAME -> WAIT_ACT on a VS falling edge.
REQ-021 In IN_FRAME, when BLANK=1 the next cycle SHALL have pix_valid=1 and pix_rgb = the sampled RGB (1-cycle latency).
- pix_x counts 0..HDISP-1 within a line; pix_y counts the active lines.
REQ-022 pix_x SHALL return to 0, and pix_y SHALL increment, on the first BLANK=1 cycle after a BLANK=0 cycle.
- pix_y resets to 0 on the VS edge.
REQ-023 The HS period counter SHALL count clocks between HS falling edges; any period != HTOTAL sets hs_err.
- The first edge after reset is not checked.
REQ-024 The VS period counter SHALL count HS falling edges between VS falling edges; any period != VTOTAL sets vs_err.
- BLANK=1 while VS=0 also sets vs_err.
REQ-025 size_err SHALL be set when a line has active pixels != HDISP, or a frame has active lines != VDISP.
- Further pixels in an overrun line saturate pix_x at HDISP-1.
- Further lines in an overrun frame saturate pix_y at VDISP-1.
REQ-026 frame_done SHALL pulse one cycle after the VS falling edge that leaves IN_FRAME; the same cycle frame_cnt increments, wrapping 65535 -> 0.
REQ-027 locked SHALL rise with frame_done when no error occurred in that frame, and SHALL fall the cycle after any error is flagged.
REQ-028 If HS and VS fall in the same cycle, both edges SHALL be processed; the VS edge takes priority for clearing the line/pixel counters.
REQ-029 If err_clr and a new error occur in the same cycle, the flag SHALL stay set.

Reset
REQ-030 With NRST=0 at a CLK edge, the outputs SHALL reset as follows:
- pix_valid, frame_done, locked, all error flags: 0.
- pix_x, pix_y, pix_rgb, frame_cnt: 0.
- FSM: WAIT_VS.
- HS/VS history flops: 1.
REQ-031 Reset in the middle of a frame SHALL drop the partial frame; no frame_done is produced for it.

Configuration
REQ-032 With VGA_MONITOR_CRC_EN defined, the block SHALL provide output frame_crc (16 bits), a CRC-16-CCITT (poly 0x1021, init 0xFFFF) over the 24-bit pixels in raster order, MSB first.
- frame_crc updates with frame_done and resets to 0xFFFF.
- Without the macro, the port and logic are absent.

Verification
REQ-033 HDISP=160, VDISP=90, other parameters at default, 3 clean frames -> frame_done pulses 3 times, frame_cnt=3, locked=1 after frame 1, no error flags.
REQ-034 One line shortened to HTOTAL-1 in frame 2 -> hs_err=1 and locked=0 the next cycle; err_clr pulse -> hs_err=0, and locked=1 after the next clean frame.
REQ-035 Line 5 carries 161 active pixels -> size_err=1, pix_x holds 159 for the extra pixel.
REQ-036 Reset asserted at line 40 of a frame -> every output is 0 on the next cycle, and the first frame_done appears only after a complete later frame.
REQ-037 HS and VS falling in the same cycle, with frame_cnt preloaded to 65535 by running frames -> frame_cnt=0 and pix_y=0 on the first line of the new frame.
REQ-038 With VGA_MONITOR_CRC_EN defined and an all-black 160x90 frame -> frame_crc equals the golden CRC computed by the bench model.
